// File: rtl/usb_cmd_decoder.sv
// USB control-word decoder: queues 16-bit control words and turns them into
// registered acquisition controls (channel select, enable, FIFO clear pulse,
// LEDs, sample-rate divider). One two-word command (D000 + argument) waits
// for its argument with a timeout; malformed commands bump a saturating
// error counter.
module usb_cmd_decoder #(
   parameter int          NUM_CHN     = 4,
   parameter int          CHN_W       = 2,
   parameter int          CMD_DEPTH   = 16,
   parameter int          CLR_LEN     = 4,
   parameter int          LED_W       = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd50,
   parameter int          ARG_TIMEOUT = 1024,
   parameter int          ERR_W       = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   input  logic [15:0]      cmd_word,
   output logic             cmd_full,
   output logic             cmd_overflow,
   output logic [CHN_W-1:0] adc_chn_sel,
   output logic             acq_enable,
   output logic             rst_data_fifo,
   output logic [LED_W-1:0] led,
   output logic [15:0]      sample_div,
   output logic [ERR_W-1:0] err_cnt,
   output logic             busy
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(ARG_TIMEOUT + 1);
   localparam int CLR_W = $clog2(CLR_LEN + 1);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(CMD_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ARG_TIMEOUT - 1);
   localparam logic [CLR_W-1:0] CLR_RELOAD = CLR_W'(CLR_LEN - 1);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT_ARG, FETCH_ARG} state_t;

   state_t             state_reg, state_next;
   logic [15:0]        mem [CMD_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               full_reg, ovf_reg;
   logic [15:0]        cmd_reg;
   logic [TMO_W-1:0]   tmo_reg;
   logic [CLR_W-1:0]   clr_cnt_reg;
   logic               clr_reg, acq_reg;
   logic [CHN_W-1:0]   chn_reg;
   logic [LED_W-1:0]   led_reg;
   logic [15:0]        div_reg;
   logic [ERR_W-1:0]   err_reg;
   logic               push, pop, err_inc;
   logic               is_acq_on, is_acq_off, is_clr, is_led, is_chn, is_div, is_bad;
   logic               chn_ok, in_decode;

   // The full check uses the pre-edge count, so a pop in the same cycle
   // never makes room for a write that arrives while full.
   assign push = cmd_valid && (count_reg != DEPTH_C);
   assign pop  = (state_reg == FETCH) || (state_reg == FETCH_ARG);

   assign is_acq_on  = (cmd_reg == 16'hF0F0);
   assign is_acq_off = (cmd_reg == 16'hF0F1);
   assign is_clr     = (cmd_reg == 16'hA0F0);
   assign is_led     = (cmd_reg[15:4] == 12'hB00);
   assign is_chn     = (cmd_reg[15:8] == 8'hC0);
   assign is_div     = (cmd_reg == 16'hD000);
   assign is_bad     = !(is_acq_on || is_acq_off || is_clr || is_led || is_chn || is_div);
   assign chn_ok     = ({1'b0, cmd_reg[7:0]} < 9'(NUM_CHN));
   assign in_decode  = (state_reg == DECODE);

   // Queue occupancy for the next cycle.
   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + CNT_W'(1);
      else if (!push && pop)
         count_next = count_reg - CNT_W'(1);
   end

   // Queue storage and command fetch; no reset so this maps onto RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= cmd_word;
      if (state_reg == FETCH)
         cmd_reg <= mem[rd_ptr_reg];
   end

   // Queue pointers, count, full flag and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_next;
         full_reg  <= (count_next == DEPTH_C);
         if (cmd_valid && !push)
            ovf_reg <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic and error strobe.
   always_comb begin
      state_next = state_reg;
      err_inc    = 1'b0;
      case (state_reg)
         IDLE:      if (count_reg != '0) state_next = FETCH;
         FETCH:     state_next = DECODE;
         DECODE: begin
            state_next = is_div ? WAIT_ARG : IDLE;
            if (is_bad || (is_chn && !chn_ok))
               err_inc = 1'b1;
         end
         WAIT_ARG: begin
            if (count_reg != '0)
               state_next = FETCH_ARG;
            else if (tmo_reg == TMO_LAST) begin
               err_inc    = 1'b1;
               state_next = IDLE;
            end
         end
         FETCH_ARG: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Control outputs, argument timeout and FIFO-clear pulse stretcher.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acq_reg     <= 1'b0;
         chn_reg     <= '0;
         led_reg     <= '1;
         div_reg     <= DEFAULT_DIV;
         err_reg     <= '0;
         tmo_reg     <= '0;
         clr_reg     <= 1'b0;
         clr_cnt_reg <= '0;
      end else begin
         if (in_decode && is_acq_on)
            acq_reg <= 1'b1;
         else if (in_decode && (is_acq_off || is_clr))
            acq_reg <= 1'b0;
         if (in_decode && is_led)
            led_reg <= cmd_reg[LED_W-1:0];
         if (in_decode && is_chn && chn_ok)
            chn_reg <= cmd_reg[CHN_W-1:0];
         if (state_reg == FETCH_ARG)
            div_reg <= mem[rd_ptr_reg];
         if (err_inc && (err_reg != '1))
            err_reg <= err_reg + ERR_W'(1);
         if (state_reg == WAIT_ARG)
            tmo_reg <= tmo_reg + TMO_W'(1);
         else
            tmo_reg <= '0;
         // A clear during an active pulse reloads the counter, extending it.
         if (in_decode && is_clr) begin
            clr_reg     <= 1'b1;
            clr_cnt_reg <= CLR_RELOAD;
         end else if (clr_cnt_reg != '0)
            clr_cnt_reg <= clr_cnt_reg - CLR_W'(1);
         else
            clr_reg <= 1'b0;
      end
   end

   assign cmd_full      = full_reg;
   assign cmd_overflow  = ovf_reg;
   assign adc_chn_sel   = chn_reg;
   assign acq_enable    = acq_reg;
   assign rst_data_fifo = clr_reg;
   assign led           = led_reg;
   assign sample_div    = div_reg;
   assign err_cnt       = err_reg;
   assign busy          = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Self-checking bench for usb_cmd_decoder: directed steps plus random
// command sequences, checked against a rule-level model of the decoder.
module tb_usb_cmd_decoder;

   localparam int NUM_CHN = 4;
   localparam int CLR_LEN = 4;
   localparam int DEPTH   = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [15:0] cmd_word = 16'h0;
   logic        cmd_full, cmd_overflow, acq_enable, rst_data_fifo, busy;
   logic [1:0]  adc_chn_sel;
   logic [3:0]  led;
   logic [15:0] sample_div;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   // Model state
   logic        m_acq, m_pend, m_ovf;
   logic [1:0]  m_chn;
   logic [3:0]  m_led;
   logic [15:0] m_div;
   logic [7:0]  m_err;

   usb_cmd_decoder dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
      .cmd_full(cmd_full), .cmd_overflow(cmd_overflow), .adc_chn_sel(adc_chn_sel),
      .acq_enable(acq_enable), .rst_data_fifo(rst_data_fifo), .led(led),
      .sample_div(sample_div), .err_cnt(err_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acq = 1'b0; m_pend = 1'b0; m_ovf = 1'b0;
      m_chn = 2'd0; m_led = 4'hF; m_div = 16'd50; m_err = 8'd0;
   endtask

   task automatic bump_err();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
   endtask

   // Decoder rules applied to one queued word.
   task automatic model_apply(input logic [15:0] w);
      if (m_pend) begin
         m_div  = w;
         m_pend = 1'b0;
      end else if (w == 16'hF0F0) m_acq = 1'b1;
      else if (w == 16'hF0F1) m_acq = 1'b0;
      else if (w == 16'hA0F0) m_acq = 1'b0;
      else if (w[15:4] == 12'hB00) m_led = w[3:0];
      else if (w[15:8] == 8'hC0) begin
         if (int'(w[7:0]) < NUM_CHN) m_chn = w[1:0];
         else bump_err();
      end else if (w == 16'hD000) m_pend = 1'b1;
      else bump_err();
   endtask

   task automatic check_all(input string tag);
      $display("txn %s: acq=%0b chn=%0d led=%0h div=%0h err=%0d ovf=%0b",
               tag, acq_enable, adc_chn_sel, led, sample_div, err_cnt, cmd_overflow);
      check({tag, ".acq"},  32'(acq_enable),   32'(m_acq));
      check({tag, ".chn"},  32'(adc_chn_sel),  32'(m_chn));
      check({tag, ".led"},  32'(led),          32'(m_led));
      check({tag, ".div"},  32'(sample_div),   32'(m_div));
      check({tag, ".err"},  32'(err_cnt),      32'(m_err));
      check({tag, ".ovf"},  32'(cmd_overflow), 32'(m_ovf));
      check({tag, ".busy"}, 32'(busy),         32'(0));
   endtask

   task automatic send_raw(input logic [15:0] w);
      cmd_valid = 1'b1;
      cmd_word  = w;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_bound", 32'(n < 3000), 32'(1));
   endtask

   // An argument that never arrives ends in a timeout error.
   task automatic settle_pending();
      if (m_pend) begin
         m_pend = 1'b0;
         bump_err();
      end
   endtask

   task automatic send_one(input string tag, input logic [15:0] w);
      send_raw(w);
      wait_idle();
      model_apply(w);
      settle_pending();
      check_all(tag);
   endtask

   task automatic send_pair(input string tag, input logic [15:0] a, input logic [15:0] b);
      send_raw(a);
      send_raw(b);
      wait_idle();
      model_apply(a);
      model_apply(b);
      settle_pending();
      check_all(tag);
   endtask

   initial begin
      int hi;
      int cnt;
      bit saw_full;
      logic [15:0] w;
      logic [15:0] last;

      // 1. Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst.full", 32'(cmd_full), 32'(0));
      check("rst.clr",  32'(rst_data_fifo), 32'(0));
      check_all("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Three-edge latency of F0F0
      send_raw(16'hF0F0);
      check("lat.e0", 32'(acq_enable), 32'(0));
      @(posedge clk); #1; check("lat.e1", 32'(acq_enable), 32'(0));
      @(posedge clk); #1; check("lat.e2", 32'(acq_enable), 32'(0));
      @(posedge clk); #1; check("lat.e3", 32'(acq_enable), 32'(1));
      wait_idle();
      model_apply(16'hF0F0);
      check_all("acq_on");
      send_one("acq_off", 16'hF0F1);

      // 2. Channel select and bad words
      send_one("chn3", 16'hC003);
      send_one("chn4_bad", 16'hC004);
      send_one("junk", 16'h1234);

      // 3. Clear pulse: single, then extended by a second clear
      send_one("acq_on2", 16'hF0F0);
      send_raw(16'hA0F0);
      hi = 0;
      for (int i = 0; i < 14; i++) begin
         if (rst_data_fifo) hi++;
         @(posedge clk); #1;
      end
      check("clr.len", 32'(hi), 32'(CLR_LEN));
      wait_idle();
      model_apply(16'hA0F0);
      check_all("clr1");

      send_raw(16'hA0F0);
      hi = 0;
      if (rst_data_fifo) hi++;
      @(posedge clk); #1;
      if (rst_data_fifo) hi++;
      cmd_valid = 1'b1;
      cmd_word  = 16'hA0F0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (rst_data_fifo) hi++;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (rst_data_fifo) hi++;
      end
      // Second clear decodes 3 cycles after the first and restarts the pulse.
      check("clr.ext", 32'(hi), 32'(3 + CLR_LEN));
      wait_idle();
      model_apply(16'hA0F0);
      model_apply(16'hA0F0);
      check_all("clr2");

      // 4. Divider argument, timeout, opcode as argument
      send_pair("div400", 16'hD000, 16'h0190);
      check("div400.val", 32'(sample_div), 32'(400));
      send_one("div_tmo", 16'hD000);
      send_pair("div_op", 16'hD000, 16'hF0F0);

      // Random command mix
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 6))
            0: w = 16'hF0F0;
            1: w = 16'hF0F1;
            2: w = 16'hA0F0;
            3: w = 16'hB000 | 16'($urandom_range(0, 15));
            4: w = 16'hC000 | 16'($urandom_range(0, 7));
            5: begin
               w = 16'($urandom);
               if (w == 16'hD000) w = 16'h5A5A;
            end
            default: w = 16'hD000;
         endcase
         if (w == 16'hD000)
            send_pair("rnd_div", w, 16'($urandom));
         else
            send_one("rnd", w);
      end

      // 5. Back-to-back LED writes overflow the queue
      cnt = 0;
      saw_full = 1'b0;
      last = 16'h0;
      for (int k = 0; k < 30; k++) begin
         w = 16'hB000 | 16'($urandom_range(0, 15));
         cmd_valid = 1'b1;
         cmd_word  = w;
         if (cnt < DEPTH) begin
            cnt++;
            last = w;
         end else
            m_ovf = 1'b1;
         // Once started, the decoder removes one word every third edge.
         if (k >= 2 && (k - 2) % 3 == 0) cnt--;
         @(posedge clk); #1;
         if (cmd_full) saw_full = 1'b1;
      end
      cmd_valid = 1'b0;
      check("ovf.saw_full", 32'(saw_full), 32'(1));
      wait_idle();
      m_led = last[3:0];
      check("ovf.full_after", 32'(cmd_full), 32'(0));
      check_all("overflow");

      // 6. Reset during WAIT_ARG with a word queued
      send_raw(16'hD000);
      repeat (6) begin
         @(posedge clk); #1;
      end
      send_raw(16'hB005);
      check("rst.busy_pre", 32'(busy), 32'(1));
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst2.full", 32'(cmd_full), 32'(0));
      check("rst2.clr",  32'(rst_data_fifo), 32'(0));
      check_all("reset_mid");
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check_all("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
